cnorm_frame: RTL

- Parametrised complex block-floating-point normaliser for the FFT output path. It is the successor of the 2-bit fixed-width normaliser.
- Applies a per-frame left shift of 0..2^SW-1 bits to complex samples, saturates instead of wrapping, and reduces NBI-bit data to NBO-bit data.
- Tracks frame boundaries with a sample counter and reports per-sample and per-frame (sticky) overflow.
- Sits between the last butterfly stage and the output buffer.

---
 rtl/cnorm_frame.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cnorm_frame.sv
// ---------------------------------------------------------------------------
// cnorm_frame -- complex block-floating-point normaliser for the FFT output
// path. Sits between the last butterfly stage and the output buffer.
//
// Every ED-qualified complex sample is left-shifted by a per-frame shift code,
// saturated to the signed NBI range, then reduced to NBO bits. Frame
// boundaries come from a sample counter started by START. Per-sample and
// per-frame (sticky) overflow are reported.
//
// Optional build macro:
//   CNORM_FRAME_ROUND_EN  - reduction rounds half-up, and saturates any result
//                           that lands above the NBO positive maximum.
//                           Undefined (default): plain truncation, with no
//                           output saturation logic.
//
// Parameters:
//   NBI       input component width (signed), NBI > NBO
//   NBO       output component width (signed)
//   SW        shift code width, max shift = 2^SW-1
//   FRAME_LEN samples per frame (power of two, >= 4)
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   ED     enable / data valid; every register advances only when ED=1
//   START  first sample of a frame (qualified by ED)
//   SHIFT  left-shift code, latched on START&ED
//   DR/DI  real / imaginary input samples
//   DOR/DOI real / imaginary output samples (2 ED cycles of latency)
//   OVF    saturation occurred on the sample now on DOR/DOI
//   RDY    marks the first output sample of a frame
//   FDONE  marks the last output sample of a frame
//   FOVF   sticky frame overflow, meaningful while FDONE=1
// ---------------------------------------------------------------------------
module cnorm_frame #(
  parameter int NBI       = 16,
  parameter int NBO       = 14,
  parameter int SW        = 2,
  parameter int FRAME_LEN = 256
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ED,
  input  logic                  START,
  input  logic [SW-1:0]         SHIFT,
  input  logic signed [NBI-1:0] DR,
  input  logic signed [NBI-1:0] DI,
  output logic signed [NBO-1:0] DOR,
  output logic signed [NBO-1:0] DOI,
  output logic                  OVF,
  output logic                  RDY,
  output logic                  FDONE,
  output logic                  FOVF
);

  localparam int MAXSH = (1 << SW) - 1;
  // Width wide enough to hold x * 2^MAXSH exactly.
  localparam int WY    = NBI + MAXSH;
  localparam int DROP  = NBI - NBO;
  localparam int CW    = $clog2(FRAME_LEN);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Returns {overflow, saturated NBI-bit value} of x * 2^s.
  function automatic logic [NBI:0] sat_shift(input logic signed [NBI-1:0] x,
                                             input logic [SW-1:0]         s);
    logic signed [WY-1:0] y;
    logic                 hi_ones;
    logic                 hi_zeros;
    y        = WY'(x);
    y        = y <<< s;
    // In range exactly when every bit from the NBI sign position upward agrees.
    hi_ones  = &y[WY-1:NBI-1];
    hi_zeros = ~|y[WY-1:NBI-1];
    if (hi_ones || hi_zeros)
      return {1'b0, y[NBI-1:0]};
    else if (y[WY-1])
      return {1'b1, 1'b1, {(NBI-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(NBI-1){1'b1}}};
  endfunction

`ifdef CNORM_FRAME_ROUND_EN
  localparam logic signed [NBI:0] HALF = (NBI+1)'(1) << (DROP - 1);

  // Returns {overflow, NBO-bit value} of round-half-up(v / 2^DROP).
  // Adding a positive half can only push past the positive limit.
  function automatic logic [NBO:0] round_sat(input logic signed [NBI-1:0] v);
    logic signed [NBI:0] t;
    logic signed [NBO:0] q;
    t = (NBI+1)'(v) + HALF;
    q = t[NBI:DROP];
    if (!q[NBO] && q[NBO-1])
      return {1'b1, 1'b0, {(NBO-1){1'b1}}};
    else
      return {1'b0, q[NBO-1:0]};
  endfunction
`else
  // floor(v / 2^DROP): keep the upper NBO bits.
  function automatic logic [NBO-1:0] trunc_out(input logic signed [NBI-1:0] v);
    return v[NBI-1:DROP];
  endfunction
`endif

  // Control state
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] shift_lat;

  // Stage-1 pipeline registers
  logic signed [NBI-1:0] sr_p1;
  logic signed [NBI-1:0] si_p1;
  logic                  ovf_p1;
  logic                  first_p1;
  logic                  last_p1;
  logic                  infrm_p1;

  // Combinational signals
  logic [SW-1:0] sh_eff;
  logic [NBI:0]  res_r;
  logic [NBI:0]  res_i;
  logic          last_c;
  logic          infrm_c;
  logic [NBO-1:0] q_r;
  logic [NBO-1:0] q_i;
  logic          ovf2;

  // The START sample already uses the new shift, the rest of the frame uses
  // the latched one.
  always_comb begin
    sh_eff  = START ? SHIFT : shift_lat;
    res_r   = sat_shift(DR, sh_eff);
    res_i   = sat_shift(DI, sh_eff);
    // START has priority: a START on the would-be last sample opens a new
    // frame and the old frame is never tagged as done.
    last_c  = !START && (state == RUN) && (cnt == CW'(FRAME_LEN - 1));
    infrm_c = START || (state == RUN);
  end

  // Frame FSM and sample counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_lat <= '0;
    end else if (ED) begin
      if (START) begin
        state     <= RUN;
        cnt       <= CW'(1);
        shift_lat <= SHIFT;
      end else if (state == RUN) begin
        if (cnt == CW'(FRAME_LEN - 1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // ---- stage 1: shift, saturate, per-sample overflow, frame tags ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_p1    <= '0;
      si_p1    <= '0;
      ovf_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      infrm_p1 <= 1'b0;
    end else if (ED) begin
      sr_p1    <= res_r[NBI-1:0];
      si_p1    <= res_i[NBI-1:0];
      ovf_p1   <= res_r[NBI] | res_i[NBI];
      first_p1 <= START;
      last_p1  <= last_c;
      infrm_p1 <= infrm_c;
    end
  end

`ifdef CNORM_FRAME_ROUND_EN
  logic [NBO:0] rnd_r;
  logic [NBO:0] rnd_i;

  always_comb begin
    rnd_r = round_sat(sr_p1);
    rnd_i = round_sat(si_p1);
    q_r   = rnd_r[NBO-1:0];
    q_i   = rnd_i[NBO-1:0];
    ovf2  = ovf_p1 | rnd_r[NBO] | rnd_i[NBO];
  end
`else
  always_comb begin
    q_r  = trunc_out(sr_p1);
    q_i  = trunc_out(si_p1);
    ovf2 = ovf_p1;
  end
`endif

  // ---- stage 2: width reduction, flags, frame sticky overflow ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOR   <= '0;
      DOI   <= '0;
      OVF   <= 1'b0;
      RDY   <= 1'b0;
      FDONE <= 1'b0;
      FOVF  <= 1'b0;
    end else if (ED) begin
      DOR   <= q_r;
      DOI   <= q_i;
      OVF   <= ovf2;
      RDY   <= first_p1;
      FDONE <= last_p1;
      // Only samples belonging to a frame feed the sticky; the first sample
      // of a frame restarts it, so it holds the previous frame's result
      // through any idle samples in between.
      if (infrm_p1)
        FOVF <= first_p1 ? ovf2 : (FOVF | ovf2);
    end
  end

endmodule
